// File: rtl/bram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// bram_fifo_ctrl
//
// Valid/ready FIFO controller wrapped around an external 1R/1W block RAM.
// The RAM has a 1-cycle registered read and no-change read mode: a cycle
// that writes loses its read. The controller owns the read/write pointers,
// gives the single RAM cycle to either a read or a write (read wins), and
// keeps a 2-entry output buffer so the consumer sees a registered stream.
//
// Read path:
//   issue   : rd_issue drives mem_rd_addr, bumps rd_ptr
//   flight  : inflight marks that mem_rd_data is valid this cycle
//   buffer  : mem_rd_data lands in ob[ob_cnt] (after any same-cycle pop)
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid       producer has data
//   in_ready       controller accepts in_data this cycle
//   in_data        write payload
//   out_valid      out_data valid (registered)
//   out_ready      consumer accepts out_data
//   out_data       head-of-FIFO payload (registered, ob[0])
//   count          entries held: RAM + in-flight read + output buffer
//   mem_wr_en      RAM byte-column write enables, all driven together
//   mem_wr_addr    RAM write address
//   mem_wr_data    RAM write data (= in_data)
//   mem_rd_addr    RAM read address
//   mem_rd_data    RAM read data, valid the cycle after a read issue
// ---------------------------------------------------------------------------
module bram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_COL    = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [ADDR_WIDTH+1:0]   count,
    output logic [NUM_COL-1:0]      mem_wr_en,
    output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data
);

    // RAM occupancy value meaning "every RAM entry is in use".
    localparam logic [ADDR_WIDTH:0] RAM_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0]    wr_ptr;
    logic [ADDR_WIDTH:0]    rd_ptr;
    logic [ADDR_WIDTH:0]    ram_cnt;

    logic                   inflight;
    logic [DATA_WIDTH-1:0]  ob0;
    logic [DATA_WIDTH-1:0]  ob1;
    logic [1:0]             ob_cnt;

    logic                   rd_issue;
    logic                   wr_fire;
    logic                   pop;

    logic [1:0]             cnt_after_pop;
    logic [1:0]             ob_cnt_n;
    logic [DATA_WIDTH-1:0]  ob0_n;
    logic [DATA_WIDTH-1:0]  ob1_n;

    assign ram_cnt = wr_ptr - rd_ptr;

    // A read is issued only when the buffer is guaranteed a free slot for
    // the returning word, counting a read that is already in flight.
    assign rd_issue = !rst && (ram_cnt != '0) &&
                      (({1'b0, ob_cnt} + {2'b00, inflight}) < 3'd2);

    // The write slot is handed out only when no read claims the RAM, so a
    // no-change-mode read is never discarded.
    assign in_ready = !rst && !rd_issue && (ram_cnt != RAM_FULL);
    assign wr_fire  = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    assign mem_wr_en   = {NUM_COL{wr_fire}};
    assign mem_wr_addr = rst ? '0 : wr_ptr[ADDR_WIDTH-1:0];
    assign mem_wr_data = in_data;
    assign mem_rd_addr = rst ? '0 : rd_ptr[ADDR_WIDTH-1:0];

    assign out_data = ob0;
    assign count    = {1'b0, ram_cnt}
                    + {{(ADDR_WIDTH+1){1'b0}}, inflight}
                    + {{ADDR_WIDTH{1'b0}}, ob_cnt};

    // ---- buffer stage: pop first, then place the returning word ----------
    always_comb begin
        ob0_n         = ob0;
        ob1_n         = ob1;
        cnt_after_pop = ob_cnt - {1'b0, pop};
        if (pop) begin
            ob0_n = ob1;
        end
        // The returning word goes into the first free slot left after the
        // pop, so a same-cycle pop and capture keep FIFO order.
        if (inflight) begin
            if (cnt_after_pop == 2'd0) begin
                ob0_n = mem_rd_data;
            end else begin
                ob1_n = mem_rd_data;
            end
        end
        ob_cnt_n = cnt_after_pop + {1'b0, inflight};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            inflight  <= 1'b0;
            ob_cnt    <= 2'd0;
            ob0       <= '0;
            ob1       <= '0;
            out_valid <= 1'b0;
        end else begin
            // ---- issue stage ---------------------------------------------
            if (rd_issue) begin
                rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(1);
            end
            if (wr_fire) begin
                wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(1);
            end
            // ---- flight stage --------------------------------------------
            inflight <= rd_issue;
            // ---- buffer stage --------------------------------------------
            ob0       <= ob0_n;
            ob1       <= ob1_n;
            ob_cnt    <= ob_cnt_n;
            out_valid <= (ob_cnt_n != 2'd0);
        end
    end

endmodule
